dii_packet_mux: RTL and testbench

Two-input, packet-atomic round-robin multiplexer for debug interconnect (DII) flit streams. It sits directly downstream of a pair of DII packet buffers and merges their outputs into one DII channel toward the ring router, never interleaving flits of different packets. It has a registered output stage, so it adds exactly one cycle of latency at full throughput.

---
 rtl/dii_packet_mux_pkg.sv | 17 +
 rtl/dii_channel.sv | 13 +
 rtl/dii_packet_mux_rr_arbiter2.sv | 21 ++
 rtl/dii_packet_mux.sv | 93 +++++++++
 tb/tb_dii_packet_mux.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/dii_packet_mux_pkg.sv
// Shared constants and port encoding for the two-input DII packet mux.
package dii_packet_mux_pkg;

  localparam int DII_WIDTH = 16;

  // A 1-bit port index; also the encoding of owner and last_grant.
  typedef logic port_t;

  localparam port_t PORT0 = 1'b0;
  localparam port_t PORT1 = 1'b1;

  // Round-robin preference: the port that did not win last time.
  function automatic port_t rr_preferred(input port_t last_grant);
    return port_t'(~last_grant);
  endfunction

endpackage

// File: rtl/dii_channel.sv
// DII flit stream: data plus packet delimiters with valid/ready handshake.
interface dii_channel #(parameter int WIDTH = 16);

  logic [WIDTH-1:0] data;
  logic             first;
  logic             last;
  logic             valid;
  logic             ready;

  modport master (output data, first, last, valid, input ready);
  modport slave  (input data, first, last, valid, output ready);

endinterface

// File: rtl/dii_packet_mux_rr_arbiter2.sv
// Combinational 2-way round-robin grant; a lone requester always wins.
module dii_rr_arbiter2
  import dii_packet_mux_pkg::*;
(
  input  logic [1:0] req,
  input  port_t      last_grant,
  output port_t      grant,
  output logic       grant_valid
);

  always_comb begin
    grant = rr_preferred(last_grant);
    case (req)
      2'b01:   grant = PORT0;
      2'b10:   grant = PORT1;
      default: grant = rr_preferred(last_grant);
    endcase
    grant_valid = |req;
  end

endmodule

// File: rtl/dii_packet_mux.sv
// Packet-atomic round-robin merge of two DII streams; one registered stage,
// full throughput, readies drop to 0 while the output register is stalled.
module dii_packet_mux
  import dii_packet_mux_pkg::*;
#(
  parameter int WIDTH = DII_WIDTH
) (
  input  logic       clk,
  input  logic       rst,
  dii_channel.slave  in0,
  dii_channel.slave  in1,
  dii_channel.master out
);

  typedef enum logic {IDLE, PASS} state_t;

  state_t           state;
  port_t            owner;
  port_t            last_grant;
  port_t            arb_grant;
  logic             arb_valid;
  port_t            sel;
  logic             sel_valid;
  logic [WIDTH-1:0] sel_data;
  logic             sel_first;
  logic             sel_last;
  logic             load;

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_first_q;
  logic             out_last_q;

  dii_rr_arbiter2 u_arb (
    .req         ({in1.valid, in0.valid}),
    .last_grant  (last_grant),
    .grant       (arb_grant),
    .grant_valid (arb_valid)
  );

  // In PASS the owner is fixed, so its ready never looks at its own valid.
  always_comb begin
    sel       = (state == PASS) ? owner : arb_grant;
    sel_valid = arb_valid;
    if (state == PASS) begin
      sel_valid = (owner == PORT1) ? in1.valid : in0.valid;
    end
    sel_data  = (sel == PORT1) ? in1.data  : in0.data;
    sel_first = (sel == PORT1) ? in1.first : in0.first;
    sel_last  = (sel == PORT1) ? in1.last  : in0.last;
  end

  assign load = !out_valid_q || out.ready;

  assign in0.ready = !rst && load && (sel == PORT0);
  assign in1.ready = !rst && load && (sel == PORT1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= PORT0;
      last_grant  <= PORT1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else if (load) begin
      out_valid_q <= sel_valid;
      out_data_q  <= sel_data;
      out_first_q <= sel_first;
      out_last_q  <= sel_last;
      if (sel_valid) begin
        case (state)
          IDLE: begin
            owner      <= sel;
            last_grant <= sel;
            if (!sel_last) state <= PASS;
          end
          PASS: begin
            if (sel_last) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign out.valid = out_valid_q;
  assign out.data  = out_data_q;
  assign out.first = out_first_q;
  assign out.last  = out_last_q;

endmodule

// File: tb/tb_dii_packet_mux.sv
// Randomized bench for dii_packet_mux against a queue-based behavioural model.
module tb_dii_packet_mux;
  import dii_packet_mux_pkg::*;

  localparam int W = 16;
  typedef logic [W+1:0] flit_t;  // {first, last, data}

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dii_channel #(.WIDTH(W)) in0_if ();
  dii_channel #(.WIDTH(W)) in1_if ();
  dii_channel #(.WIDTH(W)) out_if ();

  dii_packet_mux #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .in0 (in0_if),
    .in1 (in1_if),
    .out (out_if)
  );

  int    n_cmp = 0;
  int    n_err = 0;
  flit_t q[2][$];
  logic  pres[2];
  logic  ordy;
  int    vprob[2];
  int    rprob;

  // Model: output slot, locked port (-1 = none), last winner, and the
  // selection/load predicted for the upcoming edge.
  logic  m_ov;
  flit_t m_flit;
  int    m_lock;
  int    m_last;
  int    exp_sel;
  logic  exp_load;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ov   = 1'b0;
    m_flit = '0;
    m_lock = -1;
    m_last = 1;
    pres[0] = 1'b0;
    pres[1] = 1'b0;
    q[0].delete();
    q[1].delete();
  endtask

  task automatic push_pkt(input int p, input int len);
    logic [W-1:0] d;
    for (int i = 0; i < len; i++) begin
      d = W'($urandom);
      q[p].push_back({(i == 0), (i == len - 1), d});
    end
  endtask

  task automatic gen_pkts(input int p, input int n, input int maxlen);
    for (int k = 0; k < n; k++) push_pkt(p, $urandom_range(1, maxlen));
  endtask

  task automatic drive();
    flit_t f0, f1;
    for (int p = 0; p < 2; p++)
      if (!pres[p] && q[p].size() > 0 && $urandom_range(0, 99) < vprob[p]) pres[p] = 1'b1;
    f0 = pres[0] ? q[0][0] : '0;
    f1 = pres[1] ? q[1][0] : '0;
    in0_if.valid = pres[0];
    {in0_if.first, in0_if.last, in0_if.data} = f0;
    in1_if.valid = pres[1];
    {in1_if.first, in1_if.last, in1_if.data} = f1;
    ordy = ($urandom_range(0, 99) < rprob);
    out_if.ready = ordy;
  endtask

  task automatic predict_and_check_ready();
    exp_load = !m_ov || ordy;
    if (m_lock >= 0)           exp_sel = m_lock;
    else if (pres[0] && pres[1]) exp_sel = (m_last == 0) ? 1 : 0;
    else if (pres[1])          exp_sel = 1;
    else                       exp_sel = 0;
    if (m_lock >= 0 || pres[0] || pres[1]) begin
      chk("in0_ready", 32'(in0_if.ready), 32'(exp_load && exp_sel == 0));
      chk("in1_ready", 32'(in1_if.ready), 32'(exp_load && exp_sel == 1));
    end
  endtask

  task automatic model_update();
    flit_t f;
    logic  sv;
    sv = pres[exp_sel];
    if (exp_load) begin
      m_ov = sv;
      if (sv) begin
        f = q[exp_sel].pop_front();
        m_flit = f;
        pres[exp_sel] = 1'b0;
        if (m_lock < 0) begin
          m_last = exp_sel;
          if (!f[W]) m_lock = exp_sel;
        end else if (f[W]) begin
          m_lock = -1;
        end
      end
    end
  endtask

  task automatic check_out();
    chk("out_valid", 32'(out_if.valid), 32'(m_ov));
    if (m_ov) chk("out_flit", 32'({out_if.first, out_if.last, out_if.data}), 32'(m_flit));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_update();
    check_out();
    drive();
    #1;
    predict_and_check_ready();
  endtask

  task automatic run_phase(input int maxc);
    int c = 0;
    while ((q[0].size() > 0 || q[1].size() > 0 || m_ov) && c < maxc) begin
      step();
      c++;
    end
    chk("drained", 32'(q[0].size() + q[1].size()), 32'd0);
  endtask

  initial begin
    int c;
    rst = 1'b1;
    model_reset();
    vprob[0] = 0; vprob[1] = 0; rprob = 100;
    drive();
    in0_if.valid = 1'b1;
    in1_if.valid = 1'b1;
    #12;
    chk("rst_out_valid", 32'(out_if.valid), 32'd0);
    chk("rst_out_flit", 32'({out_if.first, out_if.last, out_if.data}), 32'd0);
    chk("rst_in0_ready", 32'(in0_if.ready), 32'd0);
    chk("rst_in1_ready", 32'(in1_if.ready), 32'd0);
    in0_if.valid = 1'b0;
    in1_if.valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    drive();
    #1;
    predict_and_check_ready();

    // Single port, fixed 3-flit packet.
    q[0].push_back({1'b1, 1'b0, 16'h0001});
    q[0].push_back({1'b0, 1'b0, 16'h0002});
    q[0].push_back({1'b0, 1'b1, 16'h0003});
    vprob[0] = 100; vprob[1] = 0; rprob = 100;
    run_phase(50);

    // Both ports always valid with 2-flit packets: A,B,A,B without gaps.
    for (int k = 0; k < 2; k++) begin push_pkt(0, 2); push_pkt(1, 2); end
    vprob[0] = 100; vprob[1] = 100;
    run_phase(50);

    // Single-flit packets on both ports every cycle.
    for (int k = 0; k < 8; k++) begin push_pkt(0, 1); push_pkt(1, 1); end
    run_phase(50);

    // Random traffic, upstream gaps and output backpressure.
    gen_pkts(0, 25, 5);
    gen_pkts(1, 25, 5);
    vprob[0] = 70; vprob[1] = 60; rprob = 45;
    run_phase(3000);

    gen_pkts(0, 15, 4);
    gen_pkts(1, 15, 4);
    vprob[0] = 100; vprob[1] = 100; rprob = 25;
    run_phase(3000);

    // Asynchronous reset in the middle of a 4-flit packet.
    push_pkt(0, 4);
    vprob[0] = 100; vprob[1] = 0; rprob = 100;
    c = 0;
    while (m_lock != 0 && c < 20) begin step(); c++; end
    chk("lock_reached", 32'(m_lock), 32'd0);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_if.valid), 32'd0);
    chk("arst_in0_ready", 32'(in0_if.ready), 32'd0);
    chk("arst_in1_ready", 32'(in1_if.ready), 32'd0);
    model_reset();
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    push_pkt(1, 3);
    vprob[0] = 0; vprob[1] = 100;
    drive();
    #1;
    predict_and_check_ready();
    run_phase(50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
